// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULH/DIVU/REMU, one bit per cycle; start-to-writeback latency is 33 cycles.
// No queueing: start is taken only when idle, and busy stays high until the one-cycle wb_en pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      dest_sel,
  output logic            busy,
  output logic            wb_en,
  output logic [4:0]      wb_sel,
  output logic [XLEN-1:0] wb_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [4:0]        sel_q, sel_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;

  // acc holds {partial product, remaining multiplier} for MUL and
  // {partial remainder, dividend shifting into quotient} for DIV.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, b_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          b_d     = src_b;
          sel_d   = dest_sel;
          acc_d   = {{XLEN{1'b0}}, src_a};
          cnt_d   = 6'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!op_q[1]) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
          acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // High half is MULH product or REMU remainder; low half is MUL or DIVU quotient.
        wb_en_d   = 1'b1;
        wb_sel_d  = sel_q;
        wb_data_d = op_q[0] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 2'd0;
      b_q       <= '0;
      sel_q     <= 5'd0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_sel_q  <= 5'd0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = busy_q;
  assign wb_en   = wb_en_q;
  assign wb_sel  = wb_sel_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected writebacks, monitor pops them on wb_en.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIVU = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  dest_sel;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
    int          edge_n;
  } exp_t;

  exp_t        sb[$];
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [4:0]  last_sel;
  logic [31:0] last_data;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .dest_sel (dest_sel),
    .busy     (busy),
    .wb_en    (wb_en),
    .wb_sel   (wb_sel),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, want, edge_cnt);
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      OP_MUL:  return p[31:0];
      OP_MULH: return p[63:32];
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge; start is sampled at the next posedge (edge_cnt+1).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input bit exp_wb);
    exp_t e;
    op = o; src_a = a; src_b = b; dest_sel = s; start = 1'b1;
    if (exp_wb) begin
      e.sel    = s;
      e.data   = ref_model(o, a, b);
      e.edge_n = edge_cnt + 1 + 33;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom; dest_sel = 5'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_wb_en", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rand_operand();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'd0;
    if (r <= 2) return 32'($urandom_range(1, 300));
    if (r == 3) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  // Monitor: samples 1 time unit after each posedge.
  initial begin
    exp_t e;
    last_sel  = 5'd0;
    last_data = 32'd0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (rst === 1'b1) begin
        last_sel  = 5'd0;
        last_data = 32'd0;
      end else if (wb_en === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb_en", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_sel", 64'(wb_sel), 64'(e.sel));
          chk("wb_data", 64'(wb_data), 64'(e.data));
          chk("wb_latency_edge", 64'(edge_cnt), 64'(e.edge_n));
        end
        last_sel  = wb_sel;
        last_data = wb_data;
      end else begin
        chk("wb_sel_hold", 64'(wb_sel), 64'(last_sel));
        chk("wb_data_hold", 64'(wb_data), 64'(last_data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0; dest_sel = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_wb_en", 64'(wb_en), 64'd0);
    chk("reset_wb_sel", 64'(wb_sel), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, each issued in the idle cycle right after the previous writeback.
    issue(OP_MUL, 32'd7, 32'd6, 5'd3, 1'b1);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(60);
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1); wait_done(60);
    issue(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1); wait_done(60);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd6, 1'b1);               wait_done(60);
    issue(OP_REMU, 32'd100, 32'd7, 5'd7, 1'b1);               wait_done(60);
    issue(OP_DIVU, 32'd5, 32'd0, 5'd8, 1'b1);                 wait_done(60);
    issue(OP_REMU, 32'd5, 32'd0, 5'd0, 1'b1);                 wait_done(60);
    chk("idle_after_wb", 64'(busy), 64'd0);

    // Start pulses and operand changes while busy must be ignored, including in DONE.
    issue(OP_MUL, 32'd1000, 32'd3000, 5'd9, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_mid_calc", 64'(busy), 64'd1);
    start = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd2; dest_sel = 5'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    chk("busy_in_done", 64'(busy), 64'd1);
    start = 1'b1; op = OP_REMU; src_a = 32'd55; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done(60);
    repeat (40) @(negedge clk);

    // Reset 10 cycles into CALC, with start held high on the same edge.
    issue(OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wb_en", 64'(wb_en), 64'd0);
    chk("abort_wb_data", 64'(wb_data), 64'd0);
    chk("abort_wb_sel", 64'(wb_sel), 64'd0);
    rst = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);

    // Randomised operations with short random idle gaps.
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
            5'($urandom_range(0, 31)), 1'b1);
      wait_done(60);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_done(60);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
